// File: rtl/div.sv
// div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        cancel_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  reg_waddr_o
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, CALC = 2'd2, END = 2'd3;
  logic [1:0] state;
  logic [2:0] op;
  logic [31:0] a, b, rem, quot, rem_n, quot_n;
  logic [33:0] diff;
  logic [4:0] count;
  logic neg_q, neg_r, sgn, zero, ovf, ge;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction
  assign sgn  = ~op[0];
  assign zero = b == 32'd0;
  assign ovf  = sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  // b holds the raw divisor in START and its magnitude during CALC
  always_comb begin
    diff   = {1'b0, rem, quot[31]} - {2'b0, b};
    ge     = ~diff[33];
    rem_n  = ge ? diff[31:0] : {rem[30:0], quot[31]};
    quot_n = {quot[30:0], ge};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= 3'd0;
      a           <= 32'd0;
      b           <= 32'd0;
      rem         <= 32'd0;
      quot        <= 32'd0;
      count       <= 5'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_o    <= 32'd0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      reg_waddr_o <= 5'd0;
    end else if (cancel_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          op          <= op_i;
          a           <= dividend_i;
          b           <= divisor_i;
          reg_waddr_o <= reg_waddr_i;
          busy_o      <= 1'b1;
          state       <= START;
        end
        START: if (zero || ovf) begin
          result_o <= op[1] ? (zero ? a : 32'd0) : (zero ? 32'hFFFF_FFFF : 32'h8000_0000);
          busy_o   <= 1'b0;
          ready_o  <= 1'b1;
          state    <= END;
        end else begin
          quot  <= mag(a, sgn);
          b     <= mag(b, sgn);
          rem   <= 32'd0;
          count <= 5'd0;
          neg_q <= sgn && (a[31] ^ b[31]);
          neg_r <= sgn && a[31];
          state <= CALC;
        end
        CALC: begin
          rem   <= rem_n;
          quot  <= quot_n;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result_o <= op[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quot_n : quot_n);
            busy_o   <= 1'b0;
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        END: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the iterative divider.
module tb_div;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, cancel_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] dividend_i = 32'd0, divisor_i = 32'd0, result_o;
  logic [4:0]  reg_waddr_i = 5'd0, reg_waddr_o;
  logic        ready_o, busy_o;
  int checks = 0, errors = 0;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i), .cancel_i(cancel_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .reg_waddr_o(reg_waddr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // called at a negedge; issues the op and waits (bounded) for the ready pulse
  task automatic run(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] wa, input logic [31:0] exp, input int lat,
                     input bit hold, input string tag);
    int k = 0, nbusy = 0;
    op_i = op; dividend_i = x; divisor_i = y; reg_waddr_i = wa; start_i = 1'b1;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (hold) begin
        dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'd31;
      end else start_i = 1'b0;
      if (ready_o) begin
        k = i;
        start_i = 1'b0;
        chk({tag, " busy_at_ready"}, {31'd0, busy_o}, 32'd0);
      end else if (busy_o) nbusy++;
    end
    chk({tag, " latency"}, k, lat);
    chk({tag, " result"}, result_o, exp);
    chk({tag, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
    chk({tag, " busy_cycles"}, nbusy, lat - 1);
    @(negedge clk);
    chk({tag, " ready_pulse"}, {31'd0, ready_o}, 32'd0);
  endtask
  initial begin
    int seen;
    #1;
    chk("reset result", result_o, 32'd0);
    chk("reset flags", {29'd0, ready_o, busy_o, 1'b0}, 32'd0);
    chk("reset waddr", {27'd0, reg_waddr_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run(DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 34, 1'b0, "divu_100_7");
    run(REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 34, 1'b0, "rem_m7_2");
    run(DIV, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 34, 1'b0, "div_m7_2");
    run(REMU, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, 34, 1'b0, "remu_fff9_2");
    run(DIV, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFF2, 34, 1'b0, "div_m100_7");
    run(REM, 32'd100, 32'hFFFF_FFF9, 5'd5, 32'd2, 34, 1'b0, "rem_100_m7");
    run(REM, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 34, 1'b0, "rem_m100_7");
    run(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 34, 1'b0, "divu_max_1");
    run(DIVU, 32'h8000_0000, 32'h0001_0000, 5'd8, 32'h0000_8000, 34, 1'b0, "divu_pow2");
    run(DIV, 32'd1234, 32'd0, 5'd9, 32'hFFFF_FFFF, 2, 1'b0, "div_by0");
    run(REMU, 32'd1234, 32'd0, 5'd11, 32'd1234, 2, 1'b0, "remu_by0");
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, 1'b0, "div_ovf");
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2, 1'b0, "rem_ovf");
    run(DIVU, 32'd50, 32'd5, 5'd14, 32'd10, 34, 1'b0, "divu_50_5");
    // start and cancel together in IDLE: start dropped
    start_i = 1'b1; cancel_i = 1'b1; op_i = DIVU; reg_waddr_i = 5'd20;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    chk("start_cancel busy", {31'd0, busy_o}, 32'd0);
    chk("start_cancel waddr", {27'd0, reg_waddr_o}, 32'd14);
    // cancel in CALC cycle 10
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd999; divisor_i = 32'd3; reg_waddr_i = 5'd21;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("cancel pre busy", {31'd0, busy_o}, 32'd1);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    chk("cancel busy", {31'd0, busy_o}, 32'd0);
    chk("cancel ready", {31'd0, ready_o}, 32'd0);
    chk("cancel result", result_o, 32'd10);
    run(DIVU, 32'd81, 32'd9, 5'd22, 32'd9, 34, 1'b0, "after_cancel");
    // start held high with changing operands is ignored while busy/END
    run(DIV, 32'd1000, 32'hFFFF_FFF6, 5'd23, 32'hFFFF_FF9C, 34, 1'b1, "held_start");
    @(negedge clk);
    chk("held_start idle", {30'd0, busy_o, ready_o}, 32'd0);
    // async reset mid-CALC
    run(REMU, 32'd17, 32'd5, 5'd24, 32'd2, 34, 1'b0, "pre_reset");
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd77; divisor_i = 32'd7; reg_waddr_i = 5'd25;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("areset result", result_o, 32'd0);
    chk("areset flags", {30'd0, busy_o, ready_o}, 32'd0);
    chk("areset waddr", {27'd0, reg_waddr_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o || busy_o) seen++;
    end
    chk("areset no_ready", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
